// File: rtl/fpdsp_seq_ctrl_if.sv
// Request/control bundle between the FP DSP sequencer and its surroundings.
// master = requester/datapath side, slave = fpdsp_seq_ctrl.
interface fpdsp_seq_ctrl_if;
  logic       run;
  logic [1:0] operation;
  logic       shift_det;
  logic       input_exc;
  logic       norm_done;
  logic       round_up;
  logic [3:0] alumode;
  logic [6:0] opmode;
  logic [4:0] inmode;
  logic       carry_in;
  logic [1:0] ram_sel;
  logic       ram_rd;
  logic       ram_we;
  logic       res_load;
  logic [4:0] iter_cnt;
  logic       busy;
  logic       ready;
  logic       err;

  modport master (
    output run, operation, shift_det, input_exc, norm_done, round_up,
    input  alumode, opmode, inmode, carry_in, ram_sel, ram_rd, ram_we,
           res_load, iter_cnt, busy, ready, err
  );

  modport slave (
    input  run, operation, shift_det, input_exc, norm_done, round_up,
    output alumode, opmode, inmode, carry_in, ram_sel, ram_rd, ram_we,
           res_load, iter_cnt, busy, ready, err
  );
endinterface

// File: rtl/fpdsp_seq_ctrl.sv
// Micro-sequencer stepping one DSP48E1 slice through an FP operation.
// Define FPDSP_DIV_EN to include the iterative divide phase (DIVIT).
module fpdsp_seq_ctrl #(
  parameter int DIV_ITERS = 24,
  parameter int NORM_MAX  = 24
) (
  input logic               clk,
  input logic               rst,
  fpdsp_seq_ctrl_if.slave   sif
);

  localparam int NW = $clog2(NORM_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, PRE, ALIGN, EXEC,
`ifdef FPDSP_DIV_EN
    DIVIT,
`endif
    NORM, ROUND, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          byp_q, byp_d, tmo_q, tmo_d, uns_q, uns_d, rnd_q, rnd_d;
  logic [NW-1:0] nrm_q, nrm_d;
`ifdef FPDSP_DIV_EN
  logic [4:0]    cnt_q, cnt_d;
`endif

  logic [3:0] alumode_q, alumode_d;
  logic [6:0] opmode_q, opmode_d;
  logic [4:0] inmode_q, inmode_d;
  logic [1:0] ram_sel_q, ram_sel_d;
  logic [4:0] iter_q, iter_d;
  logic       cin_q, cin_d, rd_q, rd_d, we_q, we_d, rl_q, rl_d;
  logic       busy_q, busy_d, ready_q, ready_d, err_q, err_d;

  // Outputs are decoded from the current state and registered, so they
  // trail the state register by one cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    byp_d     = byp_q;
    tmo_d     = tmo_q;
    uns_d     = uns_q;
    rnd_d     = rnd_q;
    nrm_d     = nrm_q;
`ifdef FPDSP_DIV_EN
    cnt_d     = cnt_q;
`endif
    alumode_d = '0;
    opmode_d  = '0;
    inmode_d  = '0;
    ram_sel_d = '0;
    iter_d    = '0;
    cin_d     = 1'b0;
    rd_d      = 1'b0;
    we_d      = 1'b0;
    rl_d      = 1'b0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (sif.run) begin
          op_d    = sif.operation;
          state_d = PRE;
        end
      end
      PRE: begin
        rd_d      = 1'b1;
        ram_sel_d = 2'd0;
        if (sif.input_exc) begin
          byp_d   = 1'b1;
          state_d = DONE;
        end else begin
          case (op_q)
            2'b00, 2'b01: state_d = sif.shift_det ? ALIGN : EXEC;
            2'b10:        state_d = EXEC;
            default: begin
`ifdef FPDSP_DIV_EN
              cnt_d   = '0;
              state_d = DIVIT;
`else
              uns_d   = 1'b1;
              state_d = DONE;
`endif
            end
          endcase
        end
      end
      ALIGN: begin
        opmode_d  = 7'b0000101;
        ram_sel_d = 2'd1;
        we_d      = 1'b1;
        state_d   = EXEC;
      end
      EXEC: begin
        case (op_q)
          2'b00: opmode_d = 7'b0110011;
          2'b01: begin
            opmode_d  = 7'b0110011;
            alumode_d = 4'b0011;
          end
          default: begin
            opmode_d = 7'b0000101;
            inmode_d = 5'b10001;
          end
        endcase
        nrm_d   = '0;
        state_d = NORM;
      end
`ifdef FPDSP_DIV_EN
      DIVIT: begin
        opmode_d  = 7'b0110011;
        alumode_d = 4'b0011;
        ram_sel_d = 2'd2;
        we_d      = 1'b1;
        iter_d    = cnt_q;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          cnt_d   = '0;
          nrm_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
`endif
      NORM: begin
        opmode_d = 7'b0000101;
        // norm_done wins over a coincident timeout.
        if (sif.norm_done) begin
          rnd_d   = sif.round_up;
          state_d = ROUND;
        end else if (nrm_q == NW'(NORM_MAX - 1)) begin
          rnd_d   = sif.round_up;
          tmo_d   = 1'b1;
          state_d = ROUND;
        end else begin
          nrm_d = nrm_q + NW'(1);
        end
      end
      ROUND: begin
        opmode_d = 7'b0110000;
        cin_d    = rnd_q;
        state_d  = DONE;
      end
      DONE: begin
        ready_d   = 1'b1;
        ram_sel_d = 2'd3;
        we_d      = 1'b1;
        rl_d      = !(byp_q || uns_q);
        err_d     = tmo_q || uns_q;
        byp_d     = 1'b0;
        tmo_d     = 1'b0;
        uns_d     = 1'b0;
        rnd_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      byp_q     <= 1'b0;
      tmo_q     <= 1'b0;
      uns_q     <= 1'b0;
      rnd_q     <= 1'b0;
      nrm_q     <= '0;
`ifdef FPDSP_DIV_EN
      cnt_q     <= '0;
`endif
      alumode_q <= '0;
      opmode_q  <= '0;
      inmode_q  <= '0;
      ram_sel_q <= '0;
      iter_q    <= '0;
      cin_q     <= 1'b0;
      rd_q      <= 1'b0;
      we_q      <= 1'b0;
      rl_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      byp_q     <= byp_d;
      tmo_q     <= tmo_d;
      uns_q     <= uns_d;
      rnd_q     <= rnd_d;
      nrm_q     <= nrm_d;
`ifdef FPDSP_DIV_EN
      cnt_q     <= cnt_d;
`endif
      alumode_q <= alumode_d;
      opmode_q  <= opmode_d;
      inmode_q  <= inmode_d;
      ram_sel_q <= ram_sel_d;
      iter_q    <= iter_d;
      cin_q     <= cin_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      rl_q      <= rl_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign sif.alumode  = alumode_q;
  assign sif.opmode   = opmode_q;
  assign sif.inmode   = inmode_q;
  assign sif.carry_in = cin_q;
  assign sif.ram_sel  = ram_sel_q;
  assign sif.ram_rd   = rd_q;
  assign sif.ram_we   = we_q;
  assign sif.res_load = rl_q;
  assign sif.iter_cnt = iter_q;
  assign sif.busy     = busy_q;
  assign sif.ready    = ready_q;
  assign sif.err      = err_q;

endmodule

// File: tb/tb_fpdsp_seq_ctrl.sv
// Directed bench for fpdsp_seq_ctrl: per-job expectations queued at issue
// and popped when ready pulses.
module tb_fpdsp_seq_ctrl;

  localparam int DITERS = 24;
  localparam int NMAX   = 24;
`ifdef FPDSP_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  typedef struct {
    int         lat;
    logic       err;
    logic       rl;
    logic [3:0] alu;
    logic       mul;
    logic       cin;
    int         norm;
    int         iters;
    logic       align;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fpdsp_seq_ctrl_if bus ();

  fpdsp_seq_ctrl #(.DIV_ITERS(DITERS), .NORM_MAX(NMAX)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic sh, input logic exc,
                                 input logic nd, input logic rup);
    exp_t e;
    int   n;
    n = nd ? 1 : NMAX;
    e.alu = 4'hF; e.mul = 1'b0; e.cin = 1'b0; e.norm = 0; e.iters = 0; e.align = 1'b0;
    if (exc) begin
      e.lat = 2; e.err = 1'b0; e.rl = 1'b0;
    end else if (op == 2'b11 && !DIV_ON) begin
      e.lat = 2; e.err = 1'b1; e.rl = 1'b0;
    end else begin
      e.norm = n; e.err = !nd; e.rl = 1'b1; e.cin = rup;
      if (op == 2'b11) begin
        e.lat = 4 + DITERS + n - 1;
        e.iters = DITERS;
      end else begin
        e.align = sh && (op != 2'b10);
        e.lat = (e.align ? 6 : 5) + n - 1;
        e.alu = (op == 2'b00) ? 4'h0 : (op == 2'b01) ? 4'h3 : 4'hF;
        e.mul = (op == 2'b10);
      end
    end
    return e;
  endfunction

  task automatic job(input string tag, input logic [1:0] op, input logic sh, input logic exc,
                     input logic nd, input logic rup, input logic ghost);
    exp_t       e;
    int         cyc, norm_n, iters;
    logic [3:0] alu_seen;
    logic       mul_seen, cin_seen, align_seen, done;
    sb.push_back(model(op, sh, exc, nd, rup));
    @(negedge clk);
    bus.operation = op; bus.shift_det = sh; bus.input_exc = exc;
    bus.norm_done = nd; bus.round_up = rup; bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    bus.operation = ~op;
    cyc = 0; norm_n = 0; iters = 0; alu_seen = 4'hF;
    mul_seen = 1'b0; cin_seen = 1'b0; align_seen = 1'b0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ghost) bus.run = (cyc == 3);
      if (bus.ready) begin
        done = 1'b1;
      end else begin
        if (bus.opmode == 7'b0110011 && !bus.ram_we) alu_seen = bus.alumode;
        if (bus.inmode == 5'b10001) mul_seen = 1'b1;
        if (bus.opmode == 7'b0110000) cin_seen = bus.carry_in;
        if (bus.ram_sel == 2'd1 && bus.ram_we) align_seen = 1'b1;
        if (bus.opmode == 7'b0000101 && bus.ram_sel == 2'd0 && !bus.ram_we && bus.inmode == 5'd0)
          norm_n++;
        if (bus.ram_sel == 2'd2 && bus.ram_we) begin
          chk({tag, ".iter_cnt"}, 32'(bus.iter_cnt), 32'(iters));
          iters++;
        end
      end
    end
    e = sb.pop_front();
    chk({tag, ".ready_seen"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
      chk({tag, ".err"}, 32'(bus.err), 32'(e.err));
      chk({tag, ".res_load"}, 32'(bus.res_load), 32'(e.rl));
      chk({tag, ".done_ram"}, {29'd0, bus.ram_we, bus.ram_sel}, {29'd0, 1'b1, 2'd3});
      chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd1);
      chk({tag, ".exec_alu"}, 32'(alu_seen), 32'(e.alu));
      chk({tag, ".mul_inmode"}, 32'(mul_seen), 32'(e.mul));
      chk({tag, ".carry_in"}, 32'(cin_seen), 32'(e.cin));
      chk({tag, ".align"}, 32'(align_seen), 32'(e.align));
      chk({tag, ".norm_cycles"}, 32'(norm_n), 32'(e.norm));
      chk({tag, ".div_iters"}, 32'(iters), 32'(e.iters));
      @(posedge clk);
      #1;
      chk({tag, ".idle_after"}, {30'd0, bus.ready, bus.busy}, 32'd0);
      if (ghost) begin
        repeat (3) begin
          @(posedge clk);
          #1;
          chk({tag, ".ghost_ignored"}, 32'(bus.busy), 32'd0);
        end
      end
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.operation = 2'b00; bus.shift_det = 1'b0;
    bus.input_exc = 1'b0; bus.norm_done = 1'b0; bus.round_up = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.outputs",
        {bus.alumode, bus.opmode, bus.inmode, bus.carry_in, bus.ram_sel, bus.ram_rd,
         bus.ram_we, bus.res_load, bus.busy, bus.ready, bus.err},
        32'd0);
    chk("reset.iter_cnt", 32'(bus.iter_cnt), 32'd0);

    job("add",       2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    job("sub_shift", 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    job("add_shift", 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    job("mul",       2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    job("div",       2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    job("exc",       2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    job("timeout",   2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    job("sub",       2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef FPDSP_DIV_EN
    begin : mid_div_reset
      int   cyc;
      logic hit;
      @(negedge clk);
      bus.operation = 2'b11; bus.input_exc = 1'b0; bus.norm_done = 1'b1; bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      cyc = 0; hit = 1'b0;
      while (!hit && cyc < 100) begin
        @(posedge clk);
        #1;
        cyc++;
        hit = bus.ram_we && bus.ram_sel == 2'd2 && bus.iter_cnt == 5'd7;
      end
      chk("divrst.reached_iter7", 32'(hit), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("divrst.iter_cnt", 32'(bus.iter_cnt), 32'd0);
      chk("divrst.outputs", {bus.busy, bus.ram_we, bus.ram_sel, bus.opmode}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("divrst.stays_idle", 32'(bus.busy), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
